// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported data RAM between
// N_CORES cores; each requester is stalled via core_wait until its access completes.
module dmem_arbiter #(
  parameter int N_CORES     = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int RAM_LATENCY = 1,
  localparam int ID_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          core_read,
  input  logic [N_CORES-1:0]          core_write,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [N_CORES-1:0]          core_wait,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        ram_re,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  localparam int IDX_W = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     grant_id_r;
  logic [3:0]          lat_cnt_r;
  logic [DATA_W-1:0]   rdata_q_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_wdata_r;
  logic                ram_re_r;
  logic                ram_we_r;
  logic                busy_r;

  logic [N_CORES-1:0]  req_s;
  logic [N_CORES-1:0]  core_wait_s;
  logic [ID_W-1:0]     winner_s;
  logic                found_s;
  logic [IDX_W-1:0]    cand_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  assign req_s = core_read | core_write;

  // Pick the first requester at or above rr_ptr, wrapping around.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      cand_s = {1'b0, rr_ptr_r} + IDX_W'(k);
      cand_s = (cand_s >= IDX_W'(N_CORES)) ? (cand_s - IDX_W'(N_CORES)) : cand_s;
      if (!found_s && req_s[cand_s[ID_W-1:0]]) begin
        winner_s = cand_s[ID_W-1:0];
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Select the winning lane's address and write data.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (winner_s == ID_W'(i)) begin
        sel_addr_s  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_s = core_wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
  end

  // Stall every requester except the one being released in RESP.
  always_comb begin
    core_wait_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_wait_s[i] = req_s[i] & ~((state_r == S_RESP) && (grant_id_r == ID_W'(i)));
    end
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          next_state_s = S_ISSUE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ISSUE: next_state_s = S_WAIT;
      S_WAIT: begin
        if (lat_cnt_r == 4'd0) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_RESP:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant, RAM command, latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      lat_cnt_r   <= 4'd0;
      rdata_q_r   <= '0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_re_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          // Strobes are launched here so they are registered during ISSUE;
          // a write wins over a simultaneous read on the same lane.
          if (found_s) begin
            grant_id_r  <= winner_s;
            ram_addr_r  <= sel_addr_s;
            ram_wdata_r <= sel_wdata_s;
            ram_we_r    <= core_write[winner_s];
            ram_re_r    <= ~core_write[winner_s];
          end else begin
            ram_re_r <= 1'b0;
            ram_we_r <= 1'b0;
          end
        end
        S_ISSUE: begin
          ram_re_r  <= 1'b0;
          ram_we_r  <= 1'b0;
          lat_cnt_r <= 4'(RAM_LATENCY - 1);
        end
        S_WAIT: begin
          if (lat_cnt_r == 4'd0) begin
            rdata_q_r <= ram_rdata;
          end else begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          if (grant_id_r == ID_W'(N_CORES - 1)) begin
            rr_ptr_r <= '0;
          end else begin
            rr_ptr_r <= grant_id_r + ID_W'(1);
          end
        end
        default: begin
          ram_re_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign core_wait  = core_wait_s;
  assign core_rdata = rdata_q_r;
  assign ram_re     = ram_re_r;
  assign ram_we     = ram_we_r;
  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign grant_id   = grant_id_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a LAT=1 instance backed by a memory model and
// a LAT=3 instance whose RAM returns a marker value only on the correct cycle.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  core_read;
  logic [3:0]  core_write;
  logic [39:0] core_addr;
  logic [127:0] core_wdata;

  logic [3:0]  wait_a, wait_b;
  logic [31:0] crdata_a, crdata_b;
  logic        re_a, re_b, we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] ram_rdata_a, ram_rdata_b;
  logic [1:0]  gid_a, gid_b;
  logic        busy_a, busy_b;

  logic [31:0] mem_a [0:1023];
  logic [31:0] stg1_b, stg2_b;
  logic [3:0]  pending;

  int checks;
  int failures;

  dmem_arbiter #(.N_CORES(4), .DATA_W(32), .ADDR_W(10), .RAM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .core_read(core_read), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wait(wait_a),
    .core_rdata(crdata_a), .ram_re(re_a), .ram_we(we_a), .ram_addr(addr_a),
    .ram_wdata(wdata_a), .ram_rdata(ram_rdata_a), .grant_id(gid_a), .busy(busy_a)
  );

  dmem_arbiter #(.N_CORES(4), .DATA_W(32), .ADDR_W(10), .RAM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .core_read(core_read), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wait(wait_b),
    .core_rdata(crdata_b), .ram_re(re_b), .ram_we(we_b), .ram_addr(addr_b),
    .ram_wdata(wdata_b), .ram_rdata(ram_rdata_b), .grant_id(gid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 RAM; returns a poison word on cycles not following a read strobe.
  always @(posedge clk) begin
    if (rst) begin
      mem_a[16] <= 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) mem_a[32+i] <= 32'h0000_1000 + i;
      ram_rdata_a <= 32'hBAD0_BAD0;
    end else begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      ram_rdata_a <= re_a ? mem_a[addr_a] : 32'hBAD0_BAD0;
    end
  end

  // Latency-3 RAM returning C0DE_0000 | addr exactly three cycles after ram_re.
  always @(posedge clk) begin
    stg1_b      <= re_b ? (32'hC0DE_0000 | {22'd0, addr_b}) : 32'hBAD0_BAD0;
    stg2_b      <= stg1_b;
    ram_rdata_b <= stg2_b;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    core_read = 4'b0000;
    core_write = 4'b0000;
    core_addr = '0;
    core_wdata = '0;
    pending = 4'b0000;

    // Reset state
    repeat (2) next_cycle();
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_re", re_a, 1'b0);
    chk("rst_we", we_a, 1'b0);
    chk("rst_gid", gid_a, 2'd0);
    chk("rst_rdata", crdata_a, 32'h0);
    chk("rst_addr", addr_a, 10'h0);
    chk("rst_wait", wait_a, 4'b0000);

    // Core 2 reads 0x10
    rst = 1'b0;
    core_addr[20 +: 10] = 10'h010;
    core_read = 4'b0100;
    #1;
    chk("t1_wait_c0", wait_a, 4'b0100);
    chk("t1_busy_c0", busy_a, 1'b0);
    next_cycle();
    chk("t1_re_c1", re_a, 1'b1);
    chk("t1_we_c1", we_a, 1'b0);
    chk("t1_addr_c1", addr_a, 10'h010);
    chk("t1_gid_c1", gid_a, 2'd2);
    chk("t1_wait_c1", wait_a, 4'b0100);
    chk("t1_busy_c1", busy_a, 1'b1);
    next_cycle();
    chk("t1_re_c2", re_a, 1'b0);
    chk("t1_wait_c2", wait_a, 4'b0100);
    next_cycle();
    chk("t1_wait_c3", wait_a, 4'b0000);
    chk("t1_rdata_c3", crdata_a, 32'hDEAD_BEEF);
    next_cycle();
    core_read = 4'b0000;
    #1;
    chk("t1_busy_c4", busy_a, 1'b0);

    // Core 0 asserts read and write together: treated as a write
    core_addr[0 +: 10] = 10'h005;
    core_wdata[0 +: 32] = 32'h0000_1234;
    core_read = 4'b0001;
    core_write = 4'b0001;
    #1;
    chk("t2_wait_c0", wait_a, 4'b0001);
    next_cycle();
    chk("t2_we_c1", we_a, 1'b1);
    chk("t2_re_c1", re_a, 1'b0);
    chk("t2_addr_c1", addr_a, 10'h005);
    chk("t2_wdata_c1", wdata_a, 32'h0000_1234);
    chk("t2_gid_c1", gid_a, 2'd0);
    next_cycle();
    chk("t2_we_c2", we_a, 1'b0);
    next_cycle();
    chk("t2_wait_c3", wait_a, 4'b0000);
    next_cycle();
    core_read = 4'b0000;
    core_write = 4'b0000;

    // Core 3 reads back address 5
    core_addr[30 +: 10] = 10'h005;
    core_read = 4'b1000;
    repeat (3) next_cycle();
    chk("t2_rb_wait", wait_a, 4'b0000);
    chk("t2_rb_gid", gid_a, 2'd3);
    chk("t2_rb_rdata", crdata_a, 32'h0000_1234);
    next_cycle();
    core_read = 4'b0000;

    // All four cores request at once: served 0,1,2,3 with RESP every 4 cycles
    for (int i = 0; i < 4; i++) core_addr[i*10 +: 10] = 10'h020 + 10'(i);
    core_read = 4'b1111;
    pending = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_wait_idle", wait_a, pending);
      next_cycle();
      chk("t3_gid", gid_a, 32'(k));
      chk("t3_re", re_a, 1'b1);
      chk("t3_addr", addr_a, 32'h20 + k);
      chk("t3_wait_issue", wait_a, pending);
      next_cycle();
      next_cycle();
      chk("t3_wait_resp", wait_a, pending & ~(4'b0001 << k));
      chk("t3_rdata", crdata_a, 32'h1000 + k);
      next_cycle();
      pending = pending & ~(4'b0001 << k);
      core_read = pending;
    end

    // Cores 0 and 1 request continuously: grants alternate
    core_read = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      next_cycle();
      chk("t4_gid", gid_a, 32'(g % 2));
      next_cycle();
      next_cycle();
      chk("t4_wait_resp", wait_a, (g % 2 == 0) ? 4'b0010 : 4'b0001);
      next_cycle();
    end
    core_read = 4'b0000;
    next_cycle();

    // Reset during WAIT with core 2 pending, then full re-service
    core_addr[20 +: 10] = 10'h010;
    core_read = 4'b0100;
    next_cycle();
    chk("t6_gid_issue", gid_a, 2'd2);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    chk("t6_busy_rst", busy_a, 1'b0);
    chk("t6_re_rst", re_a, 1'b0);
    chk("t6_we_rst", we_a, 1'b0);
    chk("t6_gid_rst", gid_a, 2'd0);
    chk("t6_rdata_rst", crdata_a, 32'h0);
    chk("t6_wait_rst", wait_a, 4'b0100);
    rst = 1'b0;
    next_cycle();
    chk("t6_re_again", re_a, 1'b1);
    chk("t6_gid_again", gid_a, 2'd2);
    next_cycle();
    chk("t6_wait_mid", wait_a, 4'b0100);
    next_cycle();
    chk("t6_wait_done", wait_a, 4'b0000);
    chk("t6_rdata_done", crdata_a, 32'hDEAD_BEEF);
    next_cycle();
    core_read = 4'b0000;

    // LAT=3 instance: core 1 reads 0x33
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("t5_idle", busy_b, 1'b0);
    core_addr[10 +: 10] = 10'h033;
    core_read = 4'b0010;
    #1;
    chk("t5_wait_c0", wait_b, 4'b0010);
    next_cycle();
    chk("t5_re_c1", re_b, 1'b1);
    chk("t5_addr_c1", addr_b, 10'h033);
    chk("t5_gid_c1", gid_b, 2'd1);
    next_cycle();
    chk("t5_re_c2", re_b, 1'b0);
    next_cycle();
    next_cycle();
    chk("t5_wait_c4", wait_b, 4'b0010);
    next_cycle();
    chk("t5_wait_c5", wait_b, 4'b0000);
    chk("t5_rdata_c5", crdata_b, 32'hC0DE_0033);
    next_cycle();
    core_read = 4'b0000;
    #1;
    chk("t5_busy_c6", busy_b, 1'b0);
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one single-ported data RAM between N_CORES processor cores of the multicore system.
- Each core's data-RAM interface (mem_read / mem_write / mem_addr / mem_data_w / mem_data_r / mem_wait) connects to one lane here.
- The block sequences each access through a fixed-latency RAM, holding each requester's mem_wait high (which stalls that core's whole pipeline) until its data or write completes.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- DATA_W, 32, data word width.
- ADDR_W, 10, data address width.
- RAM_LATENCY, 1, cycles from RAM command to valid ram_rdata (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- core_read  in  N_CORES  per-core read request (core mem_read).
- core_write  in  N_CORES  per-core write request (core mem_write).
- core_addr  in  N_CORES*ADDR_W  packed addresses; lane i = bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  packed write data.
- core_wait  out  N_CORES  per-core stall (core mem_wait); combinational.
- core_rdata  out  DATA_W  read data, broadcast to all cores; valid only for the granted core in RESP.
- ram_re  out  1  RAM read strobe, one-cycle pulse.
- ram_we  out  1  RAM write strobe, one-cycle pulse.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_re.
- grant_id  out  clog2(N_CORES)  index of the current or last granted core.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Request: req[i] = core_read[i] | core_write[i].
- Core protocol: a requesting core is stalled by core_wait and holds its address and data stable until core_wait[i] drops.
- core_wait[i] = req[i] & ~(state==RESP & grant_id==i). Purely combinational, so it rises in the same cycle a request appears.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req, choose the winner: the first requester searching upward from rr_ptr, wrapping modulo N_CORES.
  - Register grant_id, the winner's addr/wdata, and is_write = core_write[winner]; go to ISSUE.
  - With no requests, remain in IDLE.
- ISSUE (one cycle):
  - ram_addr and ram_wdata come from the latched values.
  - Assert ram_we if is_write, else ram_re. Never assert both.
  - Load lat_cnt = RAM_LATENCY-1; go to WAIT.
- WAIT:
  - If lat_cnt==0: capture ram_rdata into rdata_q (also done for writes; value don't-care) and go to RESP.
  - Otherwise decrement lat_cnt.
- RESP (one cycle):
  - core_rdata = rdata_q; core_wait[grant_id] is low, so the core advances on this edge.
  - rr_ptr <= (grant_id+1) mod N_CORES; go to IDLE.
- Latency: request to wait release = RAM_LATENCY+2 stalled cycles; release occurs in cycle RAM_LATENCY+2 after the request appears (cycle 0). Back-to-back service period = RAM_LATENCY+3 cycles.
- Read and write both asserted on one lane: treated as a write, with no read strobe.
- A request withdrawn mid-transaction is a protocol violation. The transaction still completes, and no other core is released early.
- Requests arriving during ISSUE, WAIT or RESP are not sampled until the next IDLE. Their core_wait is high immediately.
- ram_re and ram_we are low in every state except ISSUE.
- ram_addr and ram_wdata hold their last values outside ISSUE.
- Reset, applied in any state, takes effect at the next edge:
  - state=IDLE, rr_ptr=0, grant_id=0, lat_cnt=0.
  - rdata_q, core_rdata, ram_addr, ram_wdata = 0.
  - ram_re, ram_we, busy = 0.
  - core_wait follows req directly.
  - An interrupted transaction is abandoned and re-arbitrated from scratch. A write already issued stays written.

Test Plan:
- N=4, LAT=1, RAM[0x10]=0xDEADBEEF; core 2 reads 0x10 at cycle 0 -> core_wait[2]=1 in cycles 0-2; ram_re=1 with ram_addr=0x10 only in cycle 1; core_wait[2]=0 and core_rdata=0xDEADBEEF in cycle 3.
- Core 0 writes 0x1234 to addr 5 -> single ram_we pulse in cycle 1 with ram_addr=5 and ram_wdata=0x1234; a following core 3 read of addr 5 returns 0x1234.
- All four cores request in cycle 0 after reset -> served 0,1,2,3 with RESP in cycles 3, 7, 11, 15; each unserved core's core_wait stays high throughout.
- Cores 0 and 1 request continuously (each re-requests right after its RESP) -> grants alternate 0,1,0,1; neither starves.
- LAT=3, core 1 reads -> ram_re in cycle 1, rdata_q captured in cycle 4, core_wait[1] falls in cycle 5.
- rst asserted in WAIT with core 2 pending -> next cycle state IDLE, busy=0, ram_re=ram_we=0, rr_ptr=0; after release, core 2 is re-granted and served with full latency.
